// File: rtl/line_readout_ctrl.sv
// Read sequencer for the ping-pong line RAMs: address, byte phase and aligned fval/lval (LRC_TESTPAT_EN adds tp_en/tp_word).
// Latency: rd_addr/rd_phase one cycle after line_rdy; lval/fval a further OUT_LAT cycles behind rd_phase.
// Backpressure: none; one ready line is queued while busy, a further one is dropped and flagged on ovf.
module line_readout_ctrl #(
  parameter int WORDS_PER_LINE = 64,
  parameter int ADDR_W         = 8,
  parameter int GAP_CYC        = 2,
  parameter int OUT_LAT        = 2
) (
  input  logic              clk_txg,
  input  logic              rst_tx_n,
  input  logic              line_rdy,
  input  logic              line_bank,
  input  logic              frame_act,
  input  logic              ovf_clr,
`ifdef LRC_TESTPAT_EN
  input  logic              tp_en,
  output logic [23:0]       tp_word,
`endif
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_phase,
  output logic              lval,
  output logic              fval,
  output logic              busy,
  output logic              ovf,
  output logic [11:0]       line_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int WW = ADDR_W - 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_LINE - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'(GAP_CYC - 1);

  logic [1:0]         r_state;
  logic               r_bank;
  logic [WW-1:0]      r_word;
  logic [1:0]         r_phase;
  logic [GW-1:0]      r_gap_cnt;
  logic               r_pend_vld;
  logic               r_pend_bank;
  logic               r_ovf;
  logic [11:0]        r_line_cnt;
  logic               r_frame_d;
  logic               r_busy;
  logic [OUT_LAT-1:0] r_lval_sr;
  logic [OUT_LAT-1:0] r_fval_sr;

  logic [1:0]    w_state_nxt;
  logic          w_bank_nxt;
  logic [WW-1:0] w_word_nxt;
  logic [1:0]    w_phase_nxt;
  logic [GW-1:0] w_gap_nxt;
  logic          w_line_done;
  logic          w_take_pend;
  logic          w_take_new;
  logic          w_rdy;
  logic          w_pend_free;
  logic          w_store;
  logic          w_drop;
  logic          w_frame_rise;

  assign w_rdy        = line_rdy & frame_act;
  assign w_frame_rise = frame_act & ~r_frame_d;

  always_comb begin
    w_state_nxt = r_state;
    w_bank_nxt  = r_bank;
    w_word_nxt  = r_word;
    w_phase_nxt = r_phase;
    w_gap_nxt   = r_gap_cnt;
    w_line_done = 1'b0;
    w_take_pend = 1'b0;
    w_take_new  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rdy) begin
          w_state_nxt = S_READ;
          w_bank_nxt  = line_bank;
          w_word_nxt  = '0;
          w_phase_nxt = 2'd1;
          w_take_new  = 1'b1;
        end
      end
      S_READ: begin
        if (r_phase == 2'd3) begin
          if (r_word == LAST_WORD) begin
            w_state_nxt = S_GAP;
            w_word_nxt  = '0;
            w_phase_nxt = 2'd0;
            w_gap_nxt   = '0;
            w_line_done = 1'b1;
          end else begin
            w_word_nxt  = r_word + 1'b1;
            w_phase_nxt = 2'd1;
          end
        end else begin
          w_phase_nxt = r_phase + 2'd1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == LAST_GAP) begin
          // A queued line is older than one arriving now, so it goes first.
          if (r_pend_vld) begin
            w_state_nxt = S_READ;
            w_bank_nxt  = r_pend_bank;
            w_phase_nxt = 2'd1;
            w_take_pend = 1'b1;
          end else if (w_rdy) begin
            w_state_nxt = S_READ;
            w_bank_nxt  = line_bank;
            w_phase_nxt = 2'd1;
            w_take_new  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_word_nxt  = '0;
        w_phase_nxt = 2'd0;
      end
    endcase
  end

  // The slot counts as free when its current occupant starts this cycle.
  assign w_pend_free = ~r_pend_vld | w_take_pend;
  assign w_store     = w_rdy & ~w_take_new & w_pend_free;
  assign w_drop      = w_rdy & ~w_take_new & ~w_pend_free;

  always_ff @(posedge clk_txg or negedge rst_tx_n) begin
    if (!rst_tx_n) begin
      r_state     <= S_IDLE;
      r_bank      <= 1'b0;
      r_word      <= '0;
      r_phase     <= 2'd0;
      r_gap_cnt   <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_bank <= 1'b0;
      r_ovf       <= 1'b0;
      r_line_cnt  <= 12'd0;
      r_frame_d   <= 1'b0;
      r_busy      <= 1'b0;
      r_lval_sr   <= '0;
      r_fval_sr   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bank    <= w_bank_nxt;
      r_word    <= w_word_nxt;
      r_phase   <= w_phase_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_frame_d <= frame_act;
      if (w_store) begin
        r_pend_vld  <= 1'b1;
        r_pend_bank <= line_bank;
      end else if (w_take_pend) begin
        r_pend_vld  <= 1'b0;
      end
      r_ovf <= ovf_clr ? 1'b0 : (r_ovf | w_drop);
      if (w_frame_rise)
        r_line_cnt <= 12'd0;
      else if (w_line_done)
        r_line_cnt <= r_line_cnt + 12'd1;
      r_lval_sr <= OUT_LAT'({r_lval_sr, (r_phase != 2'd0)});
      r_fval_sr <= OUT_LAT'({r_fval_sr, (frame_act | r_busy)});
    end
  end

  assign rd_addr  = {r_bank, r_word};
  assign rd_phase = r_phase;
  assign lval     = r_lval_sr[OUT_LAT-1];
  assign fval     = r_fval_sr[OUT_LAT-1];
  assign busy     = r_busy;
  assign ovf      = r_ovf;
  assign line_cnt = r_line_cnt;

`ifdef LRC_TESTPAT_EN
  assign tp_word = tp_en ? {12'(r_word), 12'(r_word)} : 24'd0;
`endif

endmodule

// File: tb/tb_line_readout_ctrl.sv
// Directed bench for line_readout_ctrl: line sequencing, queuing, overflow, frame end and reset.
module tb_line_readout_ctrl;

  logic        clk_txg = 1'b0;
  logic        rst_tx_n;
  logic        line_rdy;
  logic        line_bank;
  logic        frame_act;
  logic        ovf_clr;
  logic [7:0]  rd_addr;
  logic [1:0]  rd_phase;
  logic        lval;
  logic        fval;
  logic        busy;
  logic        ovf;
  logic [11:0] line_cnt;
`ifdef LRC_TESTPAT_EN
  logic        tp_en;
  logic [23:0] tp_word;
`endif

  int total = 0;
  int bad   = 0;
  int errs;
  int lcnt;

  always #5 clk_txg = ~clk_txg;

  line_readout_ctrl dut (
    .clk_txg   (clk_txg),
    .rst_tx_n  (rst_tx_n),
    .line_rdy  (line_rdy),
    .line_bank (line_bank),
    .frame_act (frame_act),
    .ovf_clr   (ovf_clr),
`ifdef LRC_TESTPAT_EN
    .tp_en     (tp_en),
    .tp_word   (tp_word),
`endif
    .rd_addr   (rd_addr),
    .rd_phase  (rd_phase),
    .lval      (lval),
    .fval      (fval),
    .busy      (busy),
    .ovf       (ovf),
    .line_cnt  (line_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_txg);
    @(negedge clk_txg);
  endtask

  // Walks one line from its first phase=1 cycle (i=0) through both gap cycles,
  // ending at the negedge of cycle stop_at+1. Pulses line_rdy at rdy0/rdy1 and
  // drops frame_act at fall_at (-1 disables each).
  task automatic read_line(input logic bank, input int rdy0, input logic b0,
                           input int rdy1, input logic b1, input int fall_at,
                           input int stop_at, output int e, output int lc);
    logic [1:0] exp_ph;
    logic [7:0] exp_ad;
    e  = 0;
    lc = 0;
    for (int i = 0; i <= stop_at; i++) begin
      line_rdy  = (i == rdy0) || (i == rdy1);
      line_bank = (i == rdy1) ? b1 : b0;
      if (i == fall_at) frame_act = 1'b0;
      exp_ph = (i < 192) ? 2'((i % 3) + 1) : 2'd0;
      exp_ad = (i < 192) ? {bank, 7'(i / 3)} : {bank, 7'd0};
      if (rd_phase !== exp_ph || rd_addr !== exp_ad || lval !== (i >= 2) || busy !== 1'b1)
        e++;
      lc += int'(lval);
`ifdef LRC_TESTPAT_EN
      if (i == 15) chk("tp_word_w5", {8'd0, tp_word}, 32'h005005);
`endif
      step();
    end
    line_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_tx_n  = 1'b0;
    line_rdy  = 1'b0;
    line_bank = 1'b0;
    frame_act = 1'b0;
    ovf_clr   = 1'b0;
`ifdef LRC_TESTPAT_EN
    tp_en     = 1'b1;
`endif
    repeat (3) @(negedge clk_txg);
    chk("rst_outs", {6'd0, rd_addr, rd_phase, lval, fval, busy, ovf, line_cnt}, 32'd0);

    // Single line from idle, bank 0
    rst_tx_n  = 1'b1;
    frame_act = 1'b1;
    step(); step();
    chk("idle_fval", fval, 1);
    line_rdy = 1'b1; line_bank = 1'b0;
    step();
    read_line(1'b0, -1, 1'b0, -1, 1'b0, -1, 193, errs, lcnt);
    chk("a_seq", errs, 0);
    chk("a_lval_len", lcnt, 192);
    chk("a_end", {rd_phase, lval, busy}, {2'd0, 1'b0, 1'b0});
    chk("a_line_cnt", line_cnt, 1);
    chk("a_ovf", ovf, 0);

    // Second line queued during the first, bank 1
    line_rdy = 1'b1; line_bank = 1'b0;
    step();
    read_line(1'b0, 50, 1'b1, -1, 1'b0, -1, 193, errs, lcnt);
    chk("b_seq1", errs, 0);
    chk("b_restart", {rd_phase, rd_addr, lval}, {2'd1, 8'd128, 1'b0});
    read_line(1'b1, -1, 1'b0, -1, 1'b0, -1, 193, errs, lcnt);
    chk("b_seq2", errs, 0);
    chk("b_lval_len2", lcnt, 192);
    chk("b_line_cnt", line_cnt, 3);
    chk("b_ovf", ovf, 0);

    // New frame; line_rdy with frame_act low is ignored
    frame_act = 1'b0;
    step();
    line_rdy = 1'b1;
    step();
    line_rdy = 1'b0;
    step();
    chk("c_ign_rdy", {busy, rd_phase, ovf}, 0);
    frame_act = 1'b1;
    step();
    chk("c_cnt_clr", line_cnt, 0);

    // Three ready lines in one line time: third dropped
    line_rdy = 1'b1; line_bank = 1'b0;
    step();
    read_line(1'b0, 20, 1'b1, 40, 1'b0, -1, 193, errs, lcnt);
    chk("c_seq1", errs, 0);
    chk("c_ovf_set", ovf, 1);
    chk("c_restart", {rd_phase, rd_addr}, {2'd1, 8'd128});
    read_line(1'b1, -1, 1'b0, -1, 1'b0, -1, 193, errs, lcnt);
    chk("c_seq2", errs, 0);
    chk("c_idle", {busy, rd_phase}, 0);
    chk("c_line_cnt", line_cnt, 2);
    chk("c_ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("c_ovf_clr", ovf, 0);

    // frame_act falls at word 30: line finishes, fval trails busy by two cycles
    line_rdy = 1'b1; line_bank = 1'b0;
    step();
    read_line(1'b0, -1, 1'b0, -1, 1'b0, 90, 193, errs, lcnt);
    chk("d_seq", errs, 0);
    chk("d_busy_done", busy, 0);
    chk("d_fval_194", fval, 1);
    step();
    chk("d_fval_195", fval, 1);
    step();
    chk("d_fval_196", fval, 0);
    chk("d_line_cnt", line_cnt, 3);
    line_rdy = 1'b1;
    step();
    line_rdy = 1'b0;
    step();
    chk("d_ign_rdy", {busy, rd_phase, fval}, 0);

    // Reset at word 20, then a clean restart on bank 1
    frame_act = 1'b1;
    line_rdy = 1'b1; line_bank = 1'b1;
    step();
    chk("e_cnt_clr", line_cnt, 0);
    read_line(1'b1, -1, 1'b1, -1, 1'b1, -1, 59, errs, lcnt);
    chk("e_seq_part", errs, 0);
    chk("e_pre_rst", {rd_phase, rd_addr}, {2'd1, 8'd148});
    rst_tx_n = 1'b0;
    #1;
    chk("e_rst_outs", {6'd0, rd_addr, rd_phase, lval, fval, busy, ovf, line_cnt}, 32'd0);
    @(negedge clk_txg);
    rst_tx_n = 1'b1;
    step();
    line_rdy = 1'b1; line_bank = 1'b1;
    step();
    read_line(1'b1, -1, 1'b1, -1, 1'b1, -1, 193, errs, lcnt);
    chk("e_seq_full", errs, 0);
    chk("e_lval_len", lcnt, 192);
    chk("e_line_cnt", line_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
